// File: rtl/bram_port_sequencer.sv
// Port-B sequencer for the 8K x 2-bit bitmap RAM: video reads (highest priority),
// byte-wide CPU accesses split into four 2-bit beats, and a background clear engine.
module bram_port_sequencer #(
  parameter logic [1:0] CLEAR_VALUE    = 2'b00,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic        vid_valid,
  output logic [1:0]  vid_data,
  input  logic        cpu_rden,
  input  logic        cpu_wren,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_wrdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [7:0]  cpu_rddata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        ram_en,
  output logic        ram_we,
  output logic [12:0] ram_addr,
  output logic [1:0]  ram_wrdata,
  input  logic [1:0]  ram_rddata
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  asm_q, asm_d;
  logic [7:0]  rddata_q, rddata_d;
  logic        done_q, done_d;
  logic        rd_tag_q, rd_tag_d;
  logic        vid_tag_q, vid_valid_q;
  logic [1:0]  vid_data_q;
  logic        clr_busy_q, clr_busy_d;
  logic [12:0] clr_cnt_q, clr_cnt_d;
  logic        auto_q;

  logic vid_go, cpu_active, cpu_beat, clr_go;

  // Video is masked during reset so the port is quiet while state is being cleared.
  assign vid_go     = vid_req & ~reset;
  assign cpu_active = (state_q == S_WRITE) || (state_q == S_READ);
  assign cpu_beat   = cpu_active && !vid_go;
  assign clr_go     = clr_busy_q && !vid_go && !cpu_active;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_wren)      state_d = S_WRITE;
        else if (cpu_rden) state_d = S_READ;
      end
      S_WRITE: if (cpu_beat && beat_q == 2'd3) state_d = S_IDLE;
      S_READ:  if (cpu_beat && beat_q == 2'd3) state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    beat_d     = beat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    rddata_d   = rddata_q;
    done_d     = 1'b0;
    rd_tag_d   = cpu_beat && (state_q == S_READ);
    clr_busy_d = clr_busy_q;
    clr_cnt_d  = clr_cnt_q;

    if (state_q == S_IDLE && (cpu_wren || cpu_rden)) begin
      addr_d  = cpu_addr;
      wdata_d = cpu_wrdata;
      beat_d  = 2'd0;
    end
    if (cpu_beat) begin
      beat_d = beat_q + 2'd1;
      if (state_q == S_WRITE && beat_q == 2'd3) done_d = 1'b1;
    end
    // Returned words enter at the top so beat 0 ends up in the LSBs after four shifts.
    if (rd_tag_q) begin
      asm_d = {ram_rddata, asm_q[7:2]};
      if (state_q == S_DRAIN) begin
        rddata_d = {ram_rddata, asm_q[7:2]};
        done_d   = 1'b1;
      end
    end

    if (!clr_busy_q && (clr_start || auto_q)) begin
      clr_busy_d = 1'b1;
      clr_cnt_d  = 13'd0;
    end else if (clr_go) begin
      clr_cnt_d = clr_cnt_q + 13'd1;
      if (clr_cnt_q == 13'h1FFF) clr_busy_d = 1'b0;
    end
  end

  always_comb begin
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = 13'd0;
    ram_wrdata = 2'b00;
    if (vid_go) begin
      ram_en   = 1'b1;
      ram_addr = vid_addr;
    end else if (cpu_beat) begin
      ram_en   = 1'b1;
      ram_we   = (state_q == S_WRITE);
      ram_addr = {addr_q, beat_q};
      if (state_q == S_WRITE) ram_wrdata = wdata_q[{beat_q, 1'b0} +: 2];
    end else if (clr_go) begin
      ram_en     = 1'b1;
      ram_we     = 1'b1;
      ram_addr   = clr_cnt_q;
      ram_wrdata = CLEAR_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q      <= 2'd0;
      addr_q      <= 11'd0;
      wdata_q     <= 8'd0;
      asm_q       <= 8'd0;
      rddata_q    <= 8'd0;
      done_q      <= 1'b0;
      rd_tag_q    <= 1'b0;
      vid_tag_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= 2'b00;
      clr_busy_q  <= 1'b0;
      clr_cnt_q   <= 13'd0;
      auto_q      <= CLEAR_ON_RESET;
    end else begin
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      rddata_q    <= rddata_d;
      done_q      <= done_d;
      rd_tag_q    <= rd_tag_d;
      vid_tag_q   <= vid_go;
      vid_valid_q <= vid_tag_q;
      if (vid_tag_q) vid_data_q <= ram_rddata;
      clr_busy_q  <= clr_busy_d;
      clr_cnt_q   <= clr_cnt_d;
      auto_q      <= 1'b0;
    end
  end

  assign vid_valid  = vid_valid_q;
  assign vid_data   = vid_data_q;
  assign cpu_busy   = (state_q != S_IDLE);
  assign cpu_done   = done_q;
  assign cpu_rddata = rddata_q;
  assign clr_busy   = clr_busy_q;

endmodule

// File: tb/tb_bram_port_sequencer.sv
// Scoreboard bench: stimulus pushes expected video words / CPU results computed from a
// byte-level memory model; a negedge monitor pops and compares when the DUT responds.
`timescale 1ns/1ps
module tb_bram_port_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [12:0] vid_addr = '0;
  logic        vid_valid;
  logic [1:0]  vid_data;
  logic        cpu_rden = 1'b0;
  logic        cpu_wren = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic [7:0]  cpu_wrdata = '0;
  logic        cpu_busy;
  logic        cpu_done;
  logic [7:0]  cpu_rddata;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        ram_en;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [1:0]  ram_wrdata;
  logic [1:0]  ram_rddata;

  always #5 clk = ~clk;

  bram_port_sequencer dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rddata(cpu_rddata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wrdata(ram_wrdata),
    .ram_rddata(ram_rddata)
  );

  // RAM primitive stand-in, preloaded with junk so the clear is observable.
  logic [1:0] ram_mem [8192];
  bit         filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 8192; i++) ram_mem[i] <= 2'($urandom);
      filled <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wrdata;
      else        ram_rddata <= ram_mem[ram_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; bit is_rd; int due; } cpu_exp_t;
  typedef struct { logic [1:0] data; int due; } vid_exp_t;
  cpu_exp_t cpu_q[$];
  vid_exp_t vid_q[$];
  logic [7:0] model [2048];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] model_word(input logic [12:0] a);
    int b;
    b = int'(model[a[12:2]]);
    return 2'((b >> (2 * int'(a[1:0]))) & 3);
  endfunction

  // Monitor: one line per completed transaction.
  always @(negedge clk) begin
    if (vid_valid) begin
      chk("vid_q_nonempty", (vid_q.size() > 0), 1);
      if (vid_q.size() > 0) begin
        vid_exp_t e;
        e = vid_q.pop_front();
        $display("vid  cyc=%0d data=%0d exp=%0d", cyc, vid_data, e.data);
        chk("vid_data", vid_data, e.data);
        chk("vid_latency", cyc, e.due);
      end
    end
    if (cpu_done) begin
      done_cnt++;
      chk("cpu_q_nonempty", (cpu_q.size() > 0), 1);
      if (cpu_q.size() > 0) begin
        cpu_exp_t e;
        e = cpu_q.pop_front();
        $display("cpu  cyc=%0d %s rddata=%02h exp=%02h", cyc, e.is_rd ? "rd" : "wr", cpu_rddata, e.data);
        if (e.is_rd) chk("cpu_rddata", cpu_rddata, e.data);
        if (e.due != 0) chk("cpu_latency", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cpu_wren = 1'b0; cpu_rden = 1'b0; clr_start = 1'b0; vid_req = 1'b0;
  endtask

  task automatic cpu_op(input bit wr, input bit rd, input logic [10:0] a, input logic [7:0] d,
                        input int due_off);
    cpu_exp_t e;
    cpu_wren = wr; cpu_rden = rd; cpu_addr = a; cpu_wrdata = d;
    e.is_rd = !wr;
    e.data  = wr ? d : model[a];
    e.due   = (due_off != 0) ? cyc + due_off : 0;
    cpu_q.push_back(e);
    if (wr) model[a] = d;
  endtask

  task automatic vid(input logic [12:0] a);
    vid_exp_t e;
    vid_req = 1'b1; vid_addr = a;
    e.data = model_word(a);
    e.due  = cyc + 2;
    vid_q.push_back(e);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((cpu_busy || cpu_q.size() != 0 || vid_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", (n < budget), 1);
  endtask

  task automatic chk_reset_vals();
    @(negedge clk);
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_vid_data", vid_data, 0);
    chk("rst_cpu_busy", cpu_busy, 0);
    chk("rst_cpu_done", cpu_done, 0);
    chk("rst_cpu_rddata", cpu_rddata, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_ram_port", {ram_en, ram_we, ram_addr, ram_wrdata}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, dc, n;
    logic [10:0] a, last_addr;
    logic [12:0] va;
    logic [7:0]  d;
    bit wr, rd, last_wr, issued_wr, wr_live;

    for (int i = 0; i < 2048; i++) model[i] = 8'h00;
    repeat (3) step();
    chk_reset_vals();

    // Automatic clear after reset: 8192 consecutive writes of zero.
    step(); reset = 1'b0;
    @(negedge clk); chk("clr_busy_pre", clr_busy, 0);
    step();
    errs = 0;
    for (int i = 0; i < 8192; i++) begin
      @(negedge clk);
      if (i == 0) chk("clr_busy_rise", clr_busy, 1);
      if (!(ram_en && ram_we && ram_addr == 13'(i) && ram_wrdata == 2'b00 && clr_busy)) errs++;
      step();
    end
    chk("clear_seq_errors", errs, 0);
    @(negedge clk);
    chk("clr_busy_fall", clr_busy, 0);
    chk("port_idle_after_clear", {ram_en, ram_we}, 0);
    step();

    // Write 0xB4 to byte 5, checking each beat on the port.
    cpu_op(1, 0, 11'h005, 8'hB4, 5);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("wr_beat", {ram_en, ram_we, ram_addr, ram_wrdata},
          {1'b1, 1'b1, 13'(13'h14 + k), 2'((8'hB4 >> (2 * k)) & 3)});
    end
    wait_quiet(20);
    cpu_op(1, 0, 11'h7FF, 8'hC0, 5); wait_quiet(20);
    cpu_op(1, 0, 11'h006, 8'h1E, 5); wait_quiet(20);
    cpu_op(0, 1, 11'h005, 8'h00, 6); wait_quiet(20);

    // Read with video stealing cycles 2 and 3.
    cpu_op(0, 1, 11'h005, 8'h00, 8);
    step(); step(); vid(13'h1FFF);
    step(); vid(13'h1FFF);
    wait_quiet(20);

    // Ten back-to-back video reads.
    for (int i = 0; i < 10; i++) begin
      vid(13'(13'h14 + i));
      step();
    end
    wait_quiet(20);

    // Simultaneous write+read strobes, then a strobe while busy.
    dc = done_cnt;
    cpu_op(1, 1, 11'h100, 8'h5A, 5);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 1) cpu_rden = 1'b1;
      @(negedge clk);
      chk("both_beat_we", {ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 11'h100, 2'(k)});
    end
    wait_quiet(20);
    repeat (4) step();
    chk("single_done", done_cnt - dc, 1);
    cpu_op(0, 1, 11'h100, 8'h00, 6); wait_quiet(20);

    // Randomized mixed traffic.
    last_wr = 1'b0; last_addr = '0;
    for (int i = 0; i < 600; i++) begin
      issued_wr = 1'b0;
      if (!cpu_busy && $urandom_range(0, 2) == 0) begin
        wr = 1'($urandom_range(0, 1));
        rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        a  = 11'($urandom_range(0, 31));
        d  = 8'($urandom);
        cpu_op(wr, rd, a, d, 0);
        last_wr = wr; last_addr = a; issued_wr = wr;
      end
      wr_live = issued_wr || (cpu_busy && last_wr);
      if ($urandom_range(0, 2) == 0) begin
        va = 13'($urandom_range(0, 127));
        if (!(wr_live && va[12:2] == last_addr)) vid(va);
      end
      step();
    end
    wait_quiet(40);

    // Manual clear start, then reset in the middle of a CPU read.
    clr_start = 1'b1;
    step();
    @(negedge clk); chk("clr_start_busy", clr_busy, 1);
    repeat (5) step();
    cpu_op(0, 1, 11'h005, 8'h00, 0);
    step(); step(); step();
    reset = 1'b1;
    cpu_q.delete();
    dc = done_cnt;
    step();
    reset = 1'b0;
    chk_reset_vals();
    step();
    @(negedge clk);
    chk("clr_restart", {clr_busy, ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 1'b1, 13'h0000});
    n = 0;
    while (clr_busy && n < 9000) begin
      step();
      n++;
    end
    chk("clr_finish_after_reset", clr_busy, 0);
    chk("no_done_after_reset", done_cnt - dc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
